// File: rtl/delay_pipe_arb_pkg.sv
// Shared types and the round-robin pick helper for delay_pipe_arb.
// Optional build macro: DELAY_PIPE_ARB_STATS_EN (per-requester grant statistics).
package delay_pipe_arb_pkg;

    localparam int MAX_REQ = 16;
    localparam int ID_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

    typedef struct packed {
        logic            found;
        logic [ID_W-1:0] index;
    } pick_t;

    // First set bit of valid_vec at or after ptr, wrapping modulo n.
    // Scanning downwards lets the nearest candidate overwrite farther ones.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid_vec,
                                      input logic [ID_W-1:0]    ptr,
                                      input int                 n);
        pick_t      res;
        logic [4:0] idx;
        res = '0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = {1'b0, ptr} + 5'(k);
                if (idx >= 5'(n)) begin
                    idx = idx - 5'(n);
                end
                if (valid_vec[idx[3:0]]) begin
                    res.found = 1'b1;
                    res.index = idx[3:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/delay_pipe_arb_rr_arbiter.sv
// Round-robin arbiter: pointer register plus combinational pick over the eligible vector.
module rr_arbiter
    import delay_pipe_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] elig,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_any,
    output logic [ID_W-1:0]    grant_idx
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    pick_t            pick;

    assign pick      = rr_pick(MAX_REQ'(elig), ID_W'(rr_ptr_q), NUM_REQ);
    assign grant_any = pick.found;
    assign grant_idx = pick.index;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
        assign grant[gi] = pick.found && (pick.index == ID_W'(gi));
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (pick.found) begin
            rr_ptr_d = (pick.index == ID_W'(NUM_REQ - 1)) ? '0 : PTR_W'(pick.index + ID_W'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/delay_pipe_arb.sv
// Shares one fixed-latency pipeline between NUM_REQ requesters, steering beats back by tag.
// Optional build macro: DELAY_PIPE_ARB_STATS_EN adds the stat_grants counters/port.
module delay_pipe_arb
    import delay_pipe_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int LATENCY = 5,
    parameter int MAX_OUT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [WIDTH-1:0]         pipe_din,
    input  logic [WIDTH-1:0]         pipe_dout,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     drained
`ifdef DELAY_PIPE_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]    stat_grants
`endif
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);

    state_e           state_q, state_d;
    tag_t             tag_q [LATENCY];
    logic [CNT_W-1:0] out_cnt_q [NUM_REQ];
    logic [NUM_REQ-1:0] elig, grant, ret;
    logic             grant_any, tags_any;
    logic [ID_W-1:0]  grant_idx;

    // A return in this cycle frees a slot, so the requester may be granted in the same cycle.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign ret[gi]  = tag_q[LATENCY-1].valid && (tag_q[LATENCY-1].id == ID_W'(gi));
        assign elig[gi] = req_valid[gi] && (state_q == ST_RUN)
                          && ((out_cnt_q[gi] < CNT_W'(MAX_OUT)) || ret[gi]);
    end

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .elig      (elig),
        .grant     (grant),
        .grant_any (grant_any),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;
    assign rsp_valid = ret;
    assign rsp_data  = pipe_dout;
    assign drained   = !grant_any && !tags_any;

    always_comb begin
        pipe_din = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                pipe_din = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        tags_any = 1'b0;
        for (int s = 0; s < LATENCY; s++) begin
            tags_any = tags_any | tag_q[s].valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < LATENCY; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            tag_q[0] <= '{valid: grant_any, id: grant_idx};
            for (int s = 1; s < LATENCY; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                out_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i] && !ret[i]) begin
                    out_cnt_q[i] <= out_cnt_q[i] + CNT_W'(1);
                end else if (!grant[i] && ret[i]) begin
                    out_cnt_q[i] <= out_cnt_q[i] - CNT_W'(1);
                end
            end
        end
    end

    // A drain always runs to completion before enable is reconsidered.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (enable) state_d = ST_RUN;
            ST_RUN:   if (!enable) state_d = ST_DRAIN;
            ST_DRAIN: if (!tags_any) state_d = enable ? ST_RUN : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef DELAY_PIPE_ARB_STATS_EN
    logic [31:0] stat_q [NUM_REQ];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                stat_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i] && (stat_q[i] != 32'hFFFF_FFFF)) begin
                    stat_q[i] <= stat_q[i] + 32'd1;
                end
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
        assign stat_grants[gi*32 +: 32] = stat_q[gi];
    end
`endif

endmodule

// File: tb/tb_delay_pipe_arb.sv
// Directed bench for delay_pipe_arb: single-requester stall, round-robin, drain, reset, stats.
`timescale 1ns/1ps
module tb_delay_pipe_arb;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 32;
    localparam int LATENCY = 5;
    localparam int MAX_OUT = 4;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     enable;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic [WIDTH-1:0]         pipe_din;
    logic [WIDTH-1:0]         pipe_dout;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]         rsp_data;
    logic                     drained;
`ifdef DELAY_PIPE_ARB_STATS_EN
    logic [NUM_REQ*32-1:0]    stat_grants;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] base    [NUM_REQ];
    logic [31:0] src_cnt [NUM_REQ];
    logic [31:0] ret_cnt [NUM_REQ];
    logic [WIDTH-1:0] pipe_q [LATENCY];

    always #5 clk = ~clk;

    delay_pipe_arb #(
        .NUM_REQ (NUM_REQ),
        .WIDTH   (WIDTH),
        .LATENCY (LATENCY),
        .MAX_OUT (MAX_OUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .pipe_din    (pipe_din),
        .pipe_dout   (pipe_dout),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .drained     (drained)
`ifdef DELAY_PIPE_ARB_STATS_EN
        ,
        .stat_grants (stat_grants)
`endif
    );

    // Stand-in for the external, unreset shared pipeline.
    always @(posedge clk) begin
        pipe_q[0] <= pipe_din;
        for (int s = 1; s < LATENCY; s++) begin
            pipe_q[s] <= pipe_q[s-1];
        end
    end
    assign pipe_dout = pipe_q[LATENCY-1];

    always @(negedge clk) begin
        if (|rsp_valid) begin
            $display("rsp valid=%b data=%08h t=%0t", rsp_valid, rsp_data, $time);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_data();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[i*WIDTH +: WIDTH] = base[i] + src_cnt[i];
        end
    endtask

    task automatic note_transfers();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && req_ready[i]) src_cnt[i] = src_cnt[i] + 1;
        end
    endtask

    task automatic do_reset(input logic [31:0] b0, input logic [31:0] step);
        rst_n     = 1'b0;
        enable    = 1'b0;
        req_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            base[i]    = b0 + step * i;
            src_cnt[i] = 0;
            ret_cnt[i] = 0;
        end
        drive_data();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        drive_data();
    endtask

    // One requester alone: period-5 pattern of four grants and one stall.
    task automatic run_single(input int id, input int ncyc);
        logic [NUM_REQ-1:0] one;
        bit exp_g, exp_r;
        one = NUM_REQ'(1) << id;
        do_reset(32'h10, 32'h0);
        enable    = 1'b1;
        req_valid = one;
        drive_data();
        @(negedge clk);
        chk("idle_ready", req_ready, 0);
        chk("idle_drained", drained, 1);
        for (int k = 1; k <= ncyc; k++) begin
            next_cycle();
            @(negedge clk);
            exp_g = (k % 5) != 0;
            exp_r = (k >= 6) && ((k % 5) != 0);
            chk("single_ready", req_ready, exp_g ? one : '0);
            if (exp_g) chk("single_din", pipe_din, 32'h10 + src_cnt[id]);
            chk("single_rsp", rsp_valid, exp_r ? one : '0);
            if (exp_r) begin
                chk("single_rdata", rsp_data, 32'h10 + ret_cnt[id]);
                ret_cnt[id] = ret_cnt[id] + 1;
            end
            if (k >= 5) chk("single_outstanding", dut.out_cnt_q[id], 4);
            note_transfers();
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b0;
        req_valid = '0;
        req_data  = '0;

        // Single requester hits MAX_OUT and resumes on its first return.
        run_single(0, 15);
        // Requester 1 at the limit: return and grant coincide, count stays at 4.
        run_single(1, 12);

        // Round-robin with all four requesters busy.
        do_reset(32'h1000, 32'h1000);
        enable    = 1'b1;
        req_valid = 4'hF;
        drive_data();
        @(negedge clk);
        chk("rr_idle_ready", req_ready, 0);
        for (int k = 1; k <= 20; k++) begin
            int gi, ri;
            next_cycle();
            @(negedge clk);
            gi = (k - 1) % 4;
            chk("rr_ready", req_ready, 4'(1) << gi);
            chk("rr_din", pipe_din, base[gi] + src_cnt[gi]);
            if (k >= 6) begin
                ri = (k - 6) % 4;
                chk("rr_rsp", rsp_valid, 4'(1) << ri);
                chk("rr_rdata", rsp_data, base[ri] + ret_cnt[ri]);
                ret_cnt[ri] = ret_cnt[ri] + 1;
            end else begin
                chk("rr_rsp_none", rsp_valid, 0);
            end
            note_transfers();
        end

        // Drain with three beats in flight, then re-enable.
        do_reset(32'h10, 32'h0);
        enable    = 1'b1;
        req_valid = 4'b0001;
        drive_data();
        @(negedge clk);
        for (int k = 1; k <= 3; k++) begin
            next_cycle();
            if (k == 3) enable = 1'b0;
            @(negedge clk);
            chk("drain_pre_ready", req_ready, 4'b0001);
            note_transfers();
        end
        for (int k = 4; k <= 10; k++) begin
            bit exp_r;
            next_cycle();
            if (k == 10) enable = 1'b1;
            @(negedge clk);
            exp_r = (k >= 6) && (k <= 8);
            chk("drain_ready", req_ready, 0);
            chk("drain_rsp", rsp_valid, exp_r ? 4'b0001 : 4'b0000);
            if (exp_r) begin
                chk("drain_rdata", rsp_data, 32'h10 + ret_cnt[0]);
                ret_cnt[0] = ret_cnt[0] + 1;
            end
            chk("drain_drained", drained, (k >= 9) ? 1 : 0);
        end
        chk("drain_nret", ret_cnt[0], 3);
        next_cycle();
        @(negedge clk);
        chk("drain_regrant", req_ready, 4'b0001);
        chk("drain_regrant_din", pipe_din, 32'h13);

        // Asynchronous reset with five beats in flight.
        do_reset(32'h2000, 32'h100);
        enable    = 1'b1;
        req_valid = 4'hF;
        drive_data();
        @(negedge clk);
        for (int k = 1; k <= 5; k++) begin
            next_cycle();
            @(negedge clk);
            chk("pre_rst_ready", req_ready, 4'(1) << ((k - 1) % 4));
            note_transfers();
        end
        @(posedge clk);
        #1;
        chk("pre_rst_ptr", dut.u_arb.rr_ptr_q, 1);
        rst_n     = 1'b0;
        enable    = 1'b0;
        req_valid = '0;
        #1;
        chk("rst_rsp", rsp_valid, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_drained", drained, 1);
        chk("rst_din", pipe_din, 0);
        chk("rst_ptr", dut.u_arb.rr_ptr_q, 0);
        for (int i = 0; i < NUM_REQ; i++) begin
            chk("rst_outstanding", dut.out_cnt_q[i], 0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("post_rst_rsp", rsp_valid, 0);
            chk("post_rst_drained", drained, 1);
        end

`ifdef DELAY_PIPE_ARB_STATS_EN
        // 100 grants to requester 2 only.
        begin
            int n;
            do_reset(32'h3000, 32'h0);
            enable    = 1'b1;
            req_valid = 4'b0100;
            drive_data();
            n = 0;
            for (int k = 0; (k < 400) && (n < 100); k++) begin
                @(posedge clk);
                #1;
                @(negedge clk);
                if (req_ready[2]) n++;
            end
            @(posedge clk);
            #1 req_valid = '0;
            chk("stat_grant_seen", n, 100);
            @(negedge clk);
            chk("stat_req0", stat_grants[0*32 +: 32], 0);
            chk("stat_req1", stat_grants[1*32 +: 32], 0);
            chk("stat_req2", stat_grants[2*32 +: 32], 100);
            chk("stat_req3", stat_grants[3*32 +: 32], 0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
